// File: rtl/if_id_skid.sv
// IF/ID pipeline register with a one-entry skid buffer.
// Holds up to two fetched instructions (main + skid) so the fetch stage sees a
// ready signal decoded purely from registered state, while decode still gets
// one instruction per cycle under a sustained stream. All outputs are flops.
module if_id_skid #(
  parameter int unsigned         INSTR_W      = 32,
  parameter int unsigned         ADDR_W       = 14,
  parameter logic [INSTR_W-1:0]  BUBBLE_INSTR = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush_i,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [ADDR_W-1:0]  addr_i,
  output logic               out_valid_o,
  input  logic               out_ready_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [ADDR_W-1:0]  addr_o,
  output logic [1:0]         count_o
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
  logic [ADDR_W-1:0]    main_addr_q, main_addr_d;
  logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0]    skid_addr_q, skid_addr_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [1:0]           count_q, count_d;

  logic                 accept;
  logic                 consume;

  // Handshakes use the registered flags, so no input-to-ready path exists.
  assign accept  = in_valid_i & in_ready_q;
  assign consume = out_valid_q & out_ready_i;

  // Next-state, entry movement and registered status flags.
  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_addr_d  = main_addr_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_instr_d = instr_i;
          main_addr_d  = addr_i;
          state_d      = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && consume) begin
          main_instr_d = instr_i;
          main_addr_d  = addr_i;
        end else if (accept) begin
          skid_instr_d = instr_i;
          skid_addr_d  = addr_i;
          state_d      = ST_FULL;
        end else if (consume) begin
          // Main is cleared so the output shows a bubble while empty.
          main_instr_d = BUBBLE_INSTR;
          main_addr_d  = '0;
          state_d      = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (consume) begin
          main_instr_d = skid_instr_q;
          main_addr_d  = skid_addr_q;
          skid_instr_d = BUBBLE_INSTR;
          skid_addr_d  = '0;
          state_d      = ST_ONE;
        end
      end
      default: begin
        state_d      = ST_EMPTY;
        main_instr_d = BUBBLE_INSTR;
        main_addr_d  = '0;
        skid_instr_d = BUBBLE_INSTR;
        skid_addr_d  = '0;
      end
    endcase

    // Redirect wins over any handshake in the same cycle.
    if (flush_i) begin
      state_d      = ST_EMPTY;
      main_instr_d = BUBBLE_INSTR;
      main_addr_d  = '0;
      skid_instr_d = BUBBLE_INSTR;
      skid_addr_d  = '0;
    end

    in_ready_d  = (state_d != ST_FULL);
    out_valid_d = (state_d != ST_EMPTY);
    unique case (state_d)
      ST_ONE:  count_d = 2'd1;
      ST_FULL: count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  // State and entry registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_EMPTY;
      main_instr_q <= BUBBLE_INSTR;
      main_addr_q  <= '0;
      skid_instr_q <= BUBBLE_INSTR;
      skid_addr_q  <= '0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_addr_q  <= main_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      count_q      <= count_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign count_o     = count_q;
  assign instr_o     = main_instr_q;
  assign addr_o      = main_addr_q;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: directed scenarios plus a long random
// run against a queue-based model of a two-deep in-order buffer.
module tb_if_id_skid;

  localparam int unsigned IW = 32;
  localparam int unsigned AW = 14;
  localparam int unsigned SW = 1 + 1 + 2 + IW + AW;

  logic          clk = 1'b0;
  logic          rst_n, flush_i, in_valid_i, in_ready_o;
  logic          out_valid_o, out_ready_i;
  logic [IW-1:0] instr_i, instr_o;
  logic [AW-1:0] addr_i, addr_o;
  logic [1:0]    count_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] addr;
  } ent_t;

  ent_t mq[$];

  if_id_skid dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .instr_i     (instr_i),
    .addr_i      (addr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .instr_o     (instr_o),
    .addr_o      (addr_o),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  // Observed outputs packed as {valid, ready, count, instr, addr}.
  function automatic logic [SW-1:0] obs();
    return {out_valid_o, in_ready_o, count_o, instr_o, addr_o};
  endfunction

  // Expected outputs derived from the model queue.
  function automatic logic [SW-1:0] exp_snap();
    if (mq.size() == 0)
      return {1'b0, 1'b1, 2'd0, {IW{1'b0}}, {AW{1'b0}}};
    return {1'b1, (mq.size() < 2), 2'(mq.size()), mq[0].instr, mq[0].addr};
  endfunction

  // Drive one cycle of inputs, advance the model on the edge, settle #1 after.
  task automatic step(input logic rst, input logic fl, input logic iv,
                      input logic [IW-1:0] ins, input logic [AW-1:0] ad,
                      input logic ordy);
    logic acc, con;
    rst_n = rst; flush_i = fl; in_valid_i = iv;
    instr_i = ins; addr_i = ad; out_ready_i = ordy;
    acc = iv && (mq.size() < 2);
    con = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (!rst || fl) begin
      mq.delete();
    end else begin
      if (con) void'(mq.pop_front());
      if (acc) mq.push_back({ins, ad});
    end
    #1;
  endtask

  task automatic test_reset();
    logic [SW-1:0] e;
    step(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 14'h3FF, 1'b1);
    e = {1'b0, 1'b1, 2'd0, 32'd0, 14'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_first_entry();
    logic [SW-1:0] e;
    step(1'b1, 1'b0, 1'b1, 32'h00A0_0093, 14'h0004, 1'b1);
    e = {1'b1, 1'b1, 2'd1, 32'h00A0_0093, 14'h0004};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL first_entry: got %h expected %h", obs(), e);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    e = {1'b0, 1'b1, 2'd0, 32'd0, 14'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL first_drain: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_full_drain();
    logic [SW-1:0] e;
    step(1'b1, 1'b0, 1'b1, 32'h11, 14'h1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h22, 14'h2, 1'b0);
    e = {1'b1, 1'b0, 2'd2, 32'h11, 14'h1};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL full_hold: got %h expected %h", obs(), e);
    end
    // Input offered while full must be ignored; output stays A.
    step(1'b1, 1'b0, 1'b1, 32'h99, 14'h9, 1'b0);
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL full_stable: got %h expected %h", obs(), e);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    e = {1'b1, 1'b1, 2'd1, 32'h22, 14'h2};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL drain_b: got %h expected %h", obs(), e);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    e = {1'b0, 1'b1, 2'd0, 32'd0, 14'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL drain_empty: got %h expected %h", obs(), e);
    end
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] e;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b1, 32'h100 + 32'(i), 14'(i), 1'b1);
      e = {1'b1, 1'b1, 2'd1, 32'h100 + 32'(i), 14'(i)};
      checks++;
      if (obs() !== e) begin
        errors++;
        $display("FAIL stream_%0d: got %h expected %h", i, obs(), e);
      end
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_flush();
    logic [SW-1:0] e;
    step(1'b1, 1'b0, 1'b1, 32'h11, 14'h1, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h22, 14'h2, 1'b0);
    step(1'b1, 1'b1, 1'b1, 32'h33, 14'h3, 1'b1);
    e = {1'b0, 1'b1, 2'd0, 32'd0, 14'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL flush_full: got %h expected %h", obs(), e);
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
      checks++;
      if (out_valid_o !== 1'b0 || instr_o === 32'h33) begin
        errors++;
        $display("FAIL flush_leak_%0d: valid %b instr %h expected valid 0 no 33",
                 i, out_valid_o, instr_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [SW-1:0] e;
    step(1'b1, 1'b0, 1'b1, 32'h55, 14'h5, 1'b0);
    step(1'b1, 1'b0, 1'b1, 32'h66, 14'h6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h77, 14'h7, 1'b1);
    e = {1'b0, 1'b1, 2'd0, 32'd0, 14'd0};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_mid: got %h expected %h", obs(), e);
    end
    step(1'b1, 1'b0, 1'b1, 32'h44, 14'h5, 1'b0);
    e = {1'b1, 1'b1, 2'd1, 32'h44, 14'h5};
    checks++;
    if (obs() !== e) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs(), e);
    end
    step(1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
  endtask

  task automatic test_random();
    logic fl, iv, ordy;
    int   bad = 0;
    for (int i = 0; i < 10000; i++) begin
      fl   = ($urandom_range(0, 31) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      step(1'b1, fl, iv, IW'($urandom), AW'($urandom), ordy);
      checks++;
      if (obs() !== exp_snap() || count_o > 2'd2) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got %h expected %h", i, obs(), exp_snap());
        bad++;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    instr_i = '0; addr_i = '0; out_ready_i = 1'b0;
    test_reset();
    test_first_entry();
    test_full_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
